// File: rtl/sram_line_prefetcher.sv
// Arbiter read client: fetches a contiguous word span into a FWFT FIFO and streams it out.
// Optional underrun counter is enabled by defining SRAM_PREFETCH_UNDERRUN_COUNT_EN.
module sram_line_prefetcher #(
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int DATA_BUS_WIDTH    = 16,
  parameter int LENGTH_WIDTH      = 10,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDRESS_BUS_WIDTH-1:0] base_address,
  input  logic [LENGTH_WIDTH-1:0]      length,
  output logic                         busy,
  output logic                         read_request,
  output logic [ADDRESS_BUS_WIDTH-1:0] read_address,
  input  logic                         read_finished_strobe,
  input  logic [DATA_BUS_WIDTH-1:0]    read_data,
  output logic                         out_valid,
  output logic [DATA_BUS_WIDTH-1:0]    out_data,
  input  logic                         out_ready,
  output logic                         span_done
`ifdef SRAM_PREFETCH_UNDERRUN_COUNT_EN
  ,
  output logic [15:0]                  underrun_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                         r_state;
  logic [ADDRESS_BUS_WIDTH-1:0]   r_addr;
  logic [LENGTH_WIDTH-1:0]        r_remaining;
  logic                           r_req;
  logic [ADDRESS_BUS_WIDTH-1:0]   r_read_address;
  logic                           r_busy;
  logic                           r_span_done;

  logic [DATA_BUS_WIDTH-1:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]                  r_wr_ptr;
  logic [PW-1:0]                  r_rd_ptr;
  logic [CW-1:0]                  r_count;

  logic                           w_push;
  logic                           w_pop;
  logic                           w_has_room;

  assign w_push     = (r_state == S_WAIT) && read_finished_strobe;
  assign w_pop      = out_valid && out_ready;
  assign w_has_room = (r_count != DEPTH_C);

  // Gate the request in the strobe cycle so the arbiter never sees a stale request.
  assign read_request = r_req && !read_finished_strobe;
  assign read_address = r_read_address;
  assign busy         = r_busy;
  assign span_done    = r_span_done;
  assign out_valid    = (r_count != '0);
  assign out_data     = out_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_remaining    <= '0;
      r_req          <= 1'b0;
      r_read_address <= '0;
      r_busy         <= 1'b0;
      r_span_done    <= 1'b0;
    end else begin
      r_span_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !r_busy) begin
            if (length != '0) begin
              r_addr      <= base_address;
              r_remaining <= length;
              r_busy      <= 1'b1;
              r_state     <= S_ISSUE;
            end else begin
              r_span_done <= 1'b1;
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (w_has_room) begin
            r_req          <= 1'b1;
            r_read_address <= r_addr;
            r_state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (read_finished_strobe) begin
            r_req       <= 1'b0;
            r_addr      <= r_addr + ADDRESS_BUS_WIDTH'(1);
            r_remaining <= r_remaining - LENGTH_WIDTH'(1);
            if (r_remaining == LENGTH_WIDTH'(1)) begin
              r_state     <= S_IDLE;
              r_span_done <= 1'b1;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= read_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef SRAM_PREFETCH_UNDERRUN_COUNT_EN
  logic [15:0] r_underrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_underrun <= '0;
    end else if (r_busy && out_ready && !out_valid && (r_underrun != 16'hFFFF)) begin
      r_underrun <= r_underrun + 16'd1;
    end
  end

  assign underrun_count = r_underrun;
`endif

endmodule

// File: tb/tb_sram_line_prefetcher.sv
// Bench for sram_line_prefetcher: randomized-latency arbiter, span-level reference model.
// Covers the SRAM_PREFETCH_UNDERRUN_COUNT_EN counter when that macro is defined.
module tb_sram_line_prefetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_address;
  logic [9:0]  length;
  logic        busy;
  logic        read_request;
  logic [15:0] read_address;
  logic        read_finished_strobe;
  logic [15:0] read_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        span_done;
`ifdef SRAM_PREFETCH_UNDERRUN_COUNT_EN
  logic [15:0] underrun_count;
`endif

  always #5 clk = ~clk;

  sram_line_prefetcher dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .base_address         (base_address),
    .length               (length),
    .busy                 (busy),
    .read_request         (read_request),
    .read_address         (read_address),
    .read_finished_strobe (read_finished_strobe),
    .read_data            (read_data),
    .out_valid            (out_valid),
    .out_data             (out_data),
    .out_ready            (out_ready),
    .span_done            (span_done)
`ifdef SRAM_PREFETCH_UNDERRUN_COUNT_EN
    ,
    .underrun_count       (underrun_count)
`endif
  );

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } word_t;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: words owed by started spans, words sitting in the FIFO, addresses owed.
  word_t       ewords[$];
  logic [15:0] mfifo[$];
  logic [15:0] eaddr[$];
  logic        m_busy    = 1'b0;
  logic        prev_done = 1'b0;
  logic        exp_done  = 1'b0;
  logic        rdy_rand  = 1'b0;
  int          uc        = 0;

  // Arbiter model.
  logic        arb_busy  = 1'b0;
  logic        stale     = 1'b0;
  logic [15:0] arb_addr  = '0;
  int          arb_cnt   = 0;

  int n_req  = 0;
  int n_pop  = 0;
  int n_done = 0;

  function automatic logic [15:0] mem_word(logic [15:0] a);
    return a + 16'h9F00;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic nb;
    word_t w;
    logic [15:0] a;
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
    exp_done = 1'b0;
    nb = m_busy;
    if (rst) begin
      ewords.delete();
      mfifo.delete();
      eaddr.delete();
      nb    = 1'b0;
      uc    = 0;
      stale = arb_busy;
    end else begin
      if (out_valid && out_ready) begin
        if (mfifo.size() == 0) begin
          check("pop_while_model_empty", 32'(out_valid), 32'(0));
        end else begin
          check("out_data", 32'(out_data), 32'(mfifo.pop_front()));
          n_pop++;
        end
      end
      if (m_busy && out_ready && mfifo.size() == 0 && uc < 16'hFFFF) uc++;
      if (read_finished_strobe) begin
        if (stale) begin
          stale = 1'b0;
        end else if (ewords.size() > 0) begin
          w = ewords.pop_front();
          mfifo.push_back(w.data);
          if (w.last) exp_done = 1'b1;
        end
      end
      if (prev_done && m_busy) nb = 1'b0;
      if (start && !m_busy) begin
        if (length == '0) begin
          exp_done = 1'b1;
        end else begin
          nb = 1'b1;
          for (int k = 0; k < int'(length); k++) begin
            a = base_address + 16'(k);
            ewords.push_back('{data: mem_word(a), last: (k == int'(length) - 1)});
            eaddr.push_back(a);
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    m_busy    = nb;
    prev_done = exp_done;
    start     = 1'b0;
    read_finished_strobe = 1'b0;
    check("span_done", 32'(span_done), 32'(exp_done));
    check("busy", 32'(busy), 32'(m_busy));
    check("out_valid", 32'(out_valid), 32'(mfifo.size() != 0));
`ifdef SRAM_PREFETCH_UNDERRUN_COUNT_EN
    check("underrun_count", 32'(underrun_count), 32'(uc));
`endif
    if (span_done) n_done++;
    if (arb_busy) begin
      arb_cnt--;
      if (arb_cnt == 0) begin
        if (!stale) begin
          check("request_held", 32'(read_request), 32'(1));
          check("address_held", 32'(read_address), 32'(arb_addr));
        end
        read_finished_strobe = 1'b1;
        read_data = mem_word(arb_addr);
        arb_busy  = 1'b0;
      end
    end else if (read_request) begin
      arb_busy = 1'b1;
      arb_addr = read_address;
      arb_cnt  = int'($urandom_range(3, 5));
      n_req++;
      if (eaddr.size() == 0) check("spurious_request", 32'(read_request), 32'(0));
      else check("read_address", 32'(read_address), 32'(eaddr.pop_front()));
    end
  endtask

  task automatic do_start(logic [15:0] b, logic [9:0] l);
    start        = 1'b1;
    base_address = b;
    length       = l;
    tick();
  endtask

  task automatic wait_quiet(int maxc, logic need_empty, string tag);
    int c = 0;
    while (c < maxc && (m_busy || ewords.size() != 0 || arb_busy ||
                        (need_empty && mfifo.size() != 0))) begin
      tick();
      c++;
    end
    check(tag, 32'(c < maxc), 32'(1));
  endtask

  int req0, pop0, done0, c;

  initial begin
    rst = 1'b1; start = 1'b0; base_address = '0; length = '0;
    read_finished_strobe = 1'b0; read_data = '0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_read_request", 32'(read_request), 32'(0));
    check("rst_read_address", 32'(read_address), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    tick();

    // Single span of five words.
    out_ready = 1'b1;
    req0 = n_req; pop0 = n_pop; done0 = n_done;
    do_start(16'h0100, 10'd5);
    wait_quiet(200, 1'b1, "single_span_timeout");
    check("single_reqs", 32'(n_req - req0), 32'(5));
    check("single_pops", 32'(n_pop - pop0), 32'(5));
    check("single_done", 32'(n_done - done0), 32'(1));

    // FIFO full stall, then drain.
    out_ready = 1'b0;
    req0 = n_req; pop0 = n_pop;
    do_start(16'h0400, 10'd20);
    repeat (150) tick();
    check("stall_reqs", 32'(n_req - req0), 32'(8));
    check("stall_request_low", 32'(read_request), 32'(0));
    out_ready = 1'b1;
    wait_quiet(400, 1'b1, "stall_drain_timeout");
    check("stall_pops", 32'(n_pop - pop0), 32'(20));

    // Address wrap.
    req0 = n_req; pop0 = n_pop;
    do_start(16'hFFFE, 10'd4);
    wait_quiet(200, 1'b1, "wrap_timeout");
    check("wrap_reqs", 32'(n_req - req0), 32'(4));
    check("wrap_pops", 32'(n_pop - pop0), 32'(4));

    // Zero-length span.
    req0 = n_req;
    do_start(16'h0050, 10'd0);
    check("zero_len_done", 32'(span_done), 32'(1));
    repeat (5) tick();
    check("zero_len_reqs", 32'(n_req - req0), 32'(0));

    // Start while busy is ignored.
    req0 = n_req; pop0 = n_pop; done0 = n_done;
    do_start(16'h0200, 10'd6);
    repeat (4) tick();
    do_start(16'h0300, 10'd3);
    wait_quiet(300, 1'b1, "busy_start_timeout");
    check("busy_start_reqs", 32'(n_req - req0), 32'(6));
    check("busy_start_pops", 32'(n_pop - pop0), 32'(6));
    check("busy_start_done", 32'(n_done - done0), 32'(1));

    // Reset while waiting on a read with three words buffered.
    out_ready = 1'b0;
    do_start(16'h0700, 10'd10);
    c = 0;
    while (c < 200 && !(mfifo.size() == 3 && arb_busy)) begin
      tick();
      c++;
    end
    check("reset_setup_timeout", 32'(c < 200), 32'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_read_request", 32'(read_request), 32'(0));
    req0 = n_req;
    repeat (8) tick();
    check("late_strobe_reqs", 32'(n_req - req0), 32'(0));
    check("late_strobe_no_push", 32'(out_valid), 32'(0));

    // Fresh span after reset.
    out_ready = 1'b1;
    pop0 = n_pop;
    do_start(16'h0900, 10'd3);
    wait_quiet(200, 1'b1, "post_reset_timeout");
    check("post_reset_pops", 32'(n_pop - pop0), 32'(3));

    // Random back-to-back spans with a random consumer; FIFO carries over spans.
    rdy_rand = 1'b1;
    pop0 = n_pop;
    c = 0;
    for (int s = 0; s < 8; s++) begin
      logic [9:0] l;
      l = 10'($urandom_range(1, 12));
      c += int'(l);
      do_start(16'($urandom), l);
      wait_quiet(400, 1'b0, "random_span_timeout");
    end
    rdy_rand  = 1'b0;
    out_ready = 1'b1;
    wait_quiet(100, 1'b1, "random_drain_timeout");
    check("random_pops", 32'(n_pop - pop0), 32'(c));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
